// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU.
//   - opcode encodings seen on ALU_OPERATION
//   - 2-bit sub-opcodes understood by the multiply/divide unit
//   - controller state enum and a helper that classifies opcodes
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_MULHU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_REMU  = 4'b1011;

    // Low two opcode bits of the iterative group. Bit 1 selects divide,
    // bit 0 selects the "upper" register (product high word / remainder).
    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } alu_state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_multicycle_muldiv.sv
// Iterative multiply/divide datapath: one shift-add (multiply) or
// restoring-subtract (divide) step per clock for WIDTH clocks.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      load operands and begin a new operation
//   op         sub-opcode (MD_MUL / MD_MULHU / MD_DIVU / MD_REMU)
//   a, b       operands, sampled only when start=1
//   last       high during the final step; result is valid at that cycle
//   result     value the register pair will hold after the current step
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    // acc : product high word / partial remainder
    // sreg: multiplier shifting out, product low word / dividend shifting out, quotient
    // opnd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        acc_d   = acc_q;
        sreg_d  = sreg_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (start) begin
            acc_d  = '0;
            sreg_d = a;
            opnd_d = b;
            op_d   = op;
            cnt_d  = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (!op_q[1]) begin
                // Carry out of the add becomes the new top bit as the pair shifts right.
                sum = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, opnd_q} : '0);
                {acc_d, sreg_d} = {sum, sreg_q[WIDTH-1:1]};
            end else begin
                // Borrow in diff[WIDTH] means the trial subtract failed: restore.
                // A zero divisor never borrows, yielding quotient all ones and
                // the dividend shifted intact into the remainder.
                shifted = {acc_q, sreg_q[WIDTH-1]};
                diff    = shifted - {1'b0, opnd_q};
                if (!diff[WIDTH]) begin
                    acc_d  = diff[WIDTH-1:0];
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d  = shifted[WIDTH-1:0];
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            sreg_q <= '0;
            opnd_q <= '0;
            op_q   <= MD_MUL;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            sreg_q <= sreg_d;
            opnd_q <= opnd_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CNT_W'(1));
    assign result = op_q[0] ? acc_d : sreg_d;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish one clock after accept; multiply/divide ops
// run WIDTH steps in alu_muldiv and finish WIDTH+1 clocks after accept.
//
//   state | meaning
//   IDLE  | no result held, ready for an operation
//   BUSY  | iterative op stepping, input not accepted
//   DONE  | ALU_RESULT/ZERO valid, held until out_ready
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operation request handshake
//   A, B, ALU_OPERATION      operands and opcode, captured on accept
//   out_valid / out_ready    result handshake
//   ALU_RESULT, ZERO         registered result and its zero flag
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_OPERATION,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_RESULT,
    output logic             ZERO
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] md_result;
    logic             md_start;
    logic             md_last;
    logic             accept;
    logic             iter_op;
    logic [SH_W-1:0]  shamt;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign iter_op  = is_iterative(ALU_OPERATION);
    assign shamt    = B[SH_W-1:0];

    always_comb begin
        sc_result = '1;
        unique case (ALU_OPERATION)
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_ADD:  sc_result = A + B;
            OP_SUB:  sc_result = A - B;
            OP_XOR:  sc_result = A ^ B;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  sc_result = A << shamt;
            OP_SRL:  sc_result = A >> shamt;
            default: sc_result = '1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        md_start = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // From DONE an accept implies out_ready, so the held result
                // is consumed in the same edge the next op launches.
                if (accept) begin
                    if (iter_op) begin
                        state_d  = BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d  = DONE;
                        result_d = sc_result;
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (md_last) begin
                    state_d  = DONE;
                    result_d = md_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= (result_d == '0);
        end
    end

    alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (ALU_OPERATION[1:0]),
        .a      (A),
        .b      (B),
        .last   (md_last),
        .result (md_result)
    );

    assign out_valid  = (state_q == DONE);
    assign ALU_RESULT = result_q;
    assign ZERO       = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_OPERATION;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_RESULT;
    logic        ZERO;

    int checks = 0;
    int errors = 0;

    alu_multicycle dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .ALU_OPERATION (ALU_OPERATION),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_RESULT    (ALU_RESULT),
        .ZERO          (ZERO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a single-cycle op; result must be visible one cycle after accept.
    task automatic run_single(input string tag, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
        A = a; B = b; ALU_OPERATION = op; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " result"}, ALU_RESULT, exp);
        check({tag, " zero"}, ZERO, (exp == 32'h0));
    endtask

    // Issue an iterative op with out_ready=1, keep in_valid high with junk
    // operands during BUSY, and measure latency / in_ready while busy.
    task automatic run_iter(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        int cyc;
        int rdy_hi;
        cyc = 0;
        rdy_hi = 0;
        A = a; B = b; ALU_OPERATION = op; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        cyc = 1;
        A = 32'h1234_5678; B = 32'h0000_0003; ALU_OPERATION = OP_ADD;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_hi++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, cyc, 33);
        check({tag, " in_ready during busy"}, rdy_hi, 0);
        check({tag, " result"}, ALU_RESULT, exp);
        @(negedge clk);
        check({tag, " back to idle"}, out_valid, 0);
    endtask

    initial begin
        int unstable;
        int spurious;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALU_OPERATION = OP_AND;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", out_valid, 0);
        check("reset result", ALU_RESULT, 0);
        check("reset zero", ZERO, 1);
        check("reset in_ready", in_ready, 1);

        // ADD with result held while out_ready is low, then released
        run_single("add 5+7", OP_ADD, 32'd5, 32'd7, 32'd12);
        check("add in_ready while held", in_ready, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("add consumed", out_valid, 0);
        check("idle in_ready", in_ready, 1);

        // SUB then SLT back-to-back
        run_single("sub 3-3", OP_SUB, 32'd3, 32'd3, 32'd0);
        check("sub in_ready done", in_ready, 1);
        run_single("slt -1<1", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        @(negedge clk);
        check("slt consumed", out_valid, 0);

        // Remaining single-cycle ops, pipelined one per cycle
        run_single("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        run_single("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        run_single("sll", OP_SLL, 32'h0000_0001, 32'd31, 32'h8000_0000);
        run_single("srl amt wraps", OP_SRL, 32'h8000_0000, 32'd35, 32'h1000_0000);
        run_single("slt pos", OP_SLT, 32'd5, 32'hFFFF_FFFE, 32'd0);
        run_single("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_single("invalid 1100", 4'b1100, 32'd1, 32'd2, 32'hFFFF_FFFF);
        @(negedge clk);

        // Iterative ops
        run_iter("mul", OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run_iter("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
        run_iter("mul small", OP_MUL, 32'd1234, 32'd5678, 32'd7006652);
        run_iter("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_iter("remu 100%7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_iter("divu 9/0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
        run_iter("remu 9%0", OP_REMU, 32'd9, 32'd0, 32'd9);

        // OR result held 5 cycles with out_ready low, new request pending
        out_ready = 1'b0;
        run_single("or", OP_OR, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
        unstable = 0;
        A = 32'h5; B = 32'h6; ALU_OPERATION = OP_ADD; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || ALU_RESULT !== 32'h0000_00FF || ZERO !== 1'b0)
                unstable++;
        end
        check("or held stable", unstable, 0);
        out_ready = 1'b1;
        run_single("invalid 1111", 4'b1111, 32'd0, 32'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("invalid consumed", out_valid, 0);

        // Reset during BUSY cycle 10 of a DIVU
        A = 32'd100; B = 32'd7; ALU_OPERATION = OP_DIVU; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy before reset", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset mid busy out_valid", out_valid, 0);
        check("reset mid busy in_ready", in_ready, 1);
        check("reset mid busy result", ALU_RESULT, 0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("no result after abort", spurious, 0);
        run_single("add 1+1", OP_ADD, 32'd1, 32'd1, 32'd2);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
